// File: rtl/ssm_pkg.sv
// Shared definitions for the ssm sample-path blocks: packet word width,
// header codes carried in bits [133:132], and the arbiter state encoding.
package ssm_pkg;

  localparam int PKT_W = 134;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_BODY = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    GRANT_S = 2'd1,
    SEND_S  = 2'd2
  } arb_state_t;

  function automatic logic [1:0] hdr_of(input logic [PKT_W-1:0] word);
    return word[PKT_W-1 -: 2];
  endfunction

endpackage

// File: rtl/ssm_sample_arb_rr_pick.sv
// rr_pick: combinational rotating-priority picker. The channel just after
// last_grant has highest priority, wrapping modulo NUM_CH.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_vld
);

  // Scan farthest-to-nearest so the nearest requester after last_grant wins.
  always_comb begin
    logic [CH_W-1:0] pos;
    pos     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      pos = CH_W'((int'(last_grant) + i) % NUM_CH);
      if (req[pos]) begin
        gnt_idx = pos;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssm_sample_arb.sv
// ssm_sample_arb: round-robin whole-packet scheduler merging NUM_CH sampled
// streams onto one 134-bit report path, stamping source channel and counting.
module ssm_sample_arb
  import ssm_pkg::*;
#(
  parameter string PLATFORM = "Xilinx-OpenBOX-S4",
  parameter int    NUM_CH   = 4,
  parameter int    CH_W     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cnt_rst,
  input  logic [NUM_CH-1:0]        ch_valid_empty,
  output logic [NUM_CH-1:0]        ch_valid_rd,
  input  logic [NUM_CH-1:0]        ch_data_empty,
  input  logic [PKT_W*NUM_CH-1:0]  ch_data_rdata,
  output logic [NUM_CH-1:0]        ch_data_rd,
  input  logic                     pktout_data_alf,
  output logic [PKT_W-1:0]         pktout_data,
  output logic                     pktout_data_wr,
  output logic                     pktout_data_valid,
  output logic                     pktout_data_valid_wr,
  output logic [CH_W-1:0]          pktout_src_ch,
  output logic [31:0]              pkt_num,
  output logic [15:0]              err_num
);

  if (PLATFORM == "") begin : g_untagged
  end

  arb_state_t       state;
  logic [CH_W-1:0]  grant;
  logic [CH_W-1:0]  last_grant;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_vld;
  logic             first_word;
  logic             pop;
  logic             is_tail;
  logic [PKT_W-1:0] cur_word;
  logic [PKT_W-1:0] rdata_arr [NUM_CH];

  rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .req        (~ch_valid_empty),
    .last_grant (last_grant),
    .gnt_idx    (gnt_idx),
    .gnt_vld    (gnt_vld)
  );

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      rdata_arr[i] = ch_data_rdata[i*PKT_W +: PKT_W];
    end
  end

  // Data FIFOs are FWFT, so the pop must be combinational with the visible head word.
  always_comb begin
    cur_word          = rdata_arr[grant];
    is_tail           = (hdr_of(cur_word) == HDR_TAIL);
    pop               = (state == SEND_S) && !ch_data_empty[grant];
    ch_data_rd        = '0;
    ch_data_rd[grant] = pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE_S;
      grant                <= '0;
      last_grant           <= CH_W'(NUM_CH - 1);
      first_word           <= 1'b0;
      ch_valid_rd          <= '0;
      pktout_data          <= '0;
      pktout_data_wr       <= 1'b0;
      pktout_data_valid    <= 1'b0;
      pktout_data_valid_wr <= 1'b0;
      pktout_src_ch        <= '0;
    end else begin
      ch_valid_rd          <= '0;
      pktout_data_wr       <= pop;
      pktout_data_valid    <= 1'b0;
      pktout_data_valid_wr <= 1'b0;
      if (pop) pktout_data <= cur_word;
      case (state)
        IDLE_S: begin
          if (!pktout_data_alf && gnt_vld) begin
            grant                <= gnt_idx;
            ch_valid_rd[gnt_idx] <= 1'b1;
            state                <= GRANT_S;
          end
        end
        GRANT_S: begin
          pktout_src_ch <= grant;
          first_word    <= 1'b1;
          state         <= SEND_S;
        end
        SEND_S: begin
          if (pop) begin
            first_word <= 1'b0;
            if (is_tail) begin
              pktout_data_valid    <= 1'b1;
              pktout_data_valid_wr <= 1'b1;
              last_grant           <= grant;
              state                <= IDLE_S;
            end
          end
        end
        default: state <= IDLE_S;
      endcase
    end
  end

  // Statistics clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_rst) begin
      pkt_num <= '0;
      err_num <= '0;
    end else begin
      if (pop && is_tail) pkt_num <= pkt_num + 32'd1;
      if (pop && first_word && hdr_of(cur_word) != HDR_HEAD && err_num != 16'hFFFF)
        err_num <= err_num + 16'd1;
    end
  end

endmodule

// File: tb/tb_ssm_sample_arb.sv
// Scoreboard bench for ssm_sample_arb: queue-based FIFO models feed the DUT,
// a round-robin reference predicts word order, and a monitor compares outputs.
module tb_ssm_sample_arb;
  import ssm_pkg::*;

  localparam int N = 4;
  localparam int W = 134;

  typedef logic [W-1:0] word_t;
  typedef struct {
    word_t data;
    bit    tail;
    int    ch;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           cnt_rst;
  logic [N-1:0]   ch_valid_empty;
  logic [N-1:0]   ch_valid_rd;
  logic [N-1:0]   ch_data_empty;
  logic [N*W-1:0] ch_data_rdata;
  logic [N-1:0]   ch_data_rd;
  logic           pktout_data_alf;
  logic [W-1:0]   pktout_data;
  logic           pktout_data_wr;
  logic           pktout_data_valid;
  logic           pktout_data_valid_wr;
  logic [1:0]     pktout_src_ch;
  logic [31:0]    pkt_num;
  logic [15:0]    err_num;

  ssm_sample_arb #(.NUM_CH(N), .CH_W(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cnt_rst              (cnt_rst),
    .ch_valid_empty       (ch_valid_empty),
    .ch_valid_rd          (ch_valid_rd),
    .ch_data_empty        (ch_data_empty),
    .ch_data_rdata        (ch_data_rdata),
    .ch_data_rd           (ch_data_rd),
    .pktout_data_alf      (pktout_data_alf),
    .pktout_data          (pktout_data),
    .pktout_data_wr       (pktout_data_wr),
    .pktout_data_valid    (pktout_data_valid),
    .pktout_data_valid_wr (pktout_data_valid_wr),
    .pktout_src_ch        (pktout_src_ch),
    .pkt_num              (pkt_num),
    .err_num              (err_num)
  );

  // external FIFO contents as the DUT sees them
  word_t        dq [N][$];
  int           dcnt [N];
  logic [N-1:0] stall_mask;
  bit           rand_stall;

  // reference model state
  word_t mwords [N][$];
  int    mlens [N][$];
  int    m_last, m_pkt, m_err;
  exp_t  exp_q[$];
  int    exp_grant_q[$];

  int compared, failed;
  int gap, cur_grant;
  bit in_pkt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [199:0] act, input logic [199:0] expv);
    compared++;
    if (act !== expv) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic recordFail(input string name, input int info);
    compared++;
    failed++;
    $display("[TB] FAIL %s: got event (info %0d) expected none", name, info);
  endtask

  task automatic refreshInputs();
    for (int i = 0; i < N; i++) begin
      ch_valid_empty[i]       = (dcnt[i] == 0);
      ch_data_empty[i]        = (dq[i].size() == 0) || stall_mask[i];
      ch_data_rdata[i*W +: W] = (dq[i].size() > 0) ? dq[i][0] : '0;
    end
  endtask

  task automatic applyStimulus(input int ch, input int len, input bit bad);
    word_t        w;
    logic [159:0] p;
    logic [1:0]   h;
    for (int k = 0; k < len; k++) begin
      p = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      if (k == len - 1)       h = HDR_TAIL;
      else if (k == 0 && !bad) h = HDR_HEAD;
      else                    h = HDR_BODY;
      w = {h, p[131:0]};
      dq[ch].push_back(w);
      mwords[ch].push_back(w);
    end
    mlens[ch].push_back(len);
    dcnt[ch]++;
    refreshInputs();
  endtask

  // Round-robin over whatever packets are pending: next channel after the last served.
  task automatic modelSchedule();
    int   ch;
    int   len;
    exp_t e;
    while (1) begin
      ch = -1;
      for (int k = 1; k <= N; k++) begin
        if (ch < 0 && mlens[(m_last + k) % N].size() > 0) ch = (m_last + k) % N;
      end
      if (ch < 0) break;
      len = mlens[ch].pop_front();
      exp_grant_q.push_back(ch);
      for (int k = 0; k < len; k++) begin
        e.data = mwords[ch].pop_front();
        e.tail = (k == len - 1);
        e.ch   = ch;
        if (k == 0 && e.data[W-1 -: 2] != 2'b01 && m_err < 65535) m_err++;
        exp_q.push_back(e);
      end
      m_pkt++;
      m_last = ch;
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < N; i++) begin
      mwords[i].delete();
      mlens[i].delete();
    end
    exp_q.delete();
    exp_grant_q.delete();
    m_last = N - 1;
    m_pkt  = 0;
    m_err  = 0;
    in_pkt = 0;
  endtask

  task automatic waitDrain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_grant_q.size() != 0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp_grant_q.size() != 0) begin
      recordFail("drain_timeout", exp_q.size());
      exp_q.delete();
      exp_grant_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic waitWord(input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pktout_data_wr && n < max_cycles);
    if (!pktout_data_wr) recordFail("word_timeout", n);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_pkt_num"}, 200'(pkt_num), 200'(m_pkt));
    checkOutput({tag, "_err_num"}, 200'(err_num), 200'(m_err));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput(tag, 200'({ch_valid_rd, ch_data_rd, pktout_data, pktout_data_wr, pktout_data_valid,
                           pktout_data_valid_wr, pktout_src_ch, pkt_num, err_num}), 200'(0));
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clearModel();
  endtask

  // FIFO model: pops observed at the edge take effect just after it.
  initial begin : fifo_model
    logic [N-1:0] drd, vrd;
    logic         r;
    forever begin
      @(posedge clk);
      drd = ch_data_rd;
      vrd = ch_valid_rd;
      r   = rst;
      #1;
      for (int i = 0; i < N; i++) begin
        if (r) begin
          dq[i].delete();
          dcnt[i] = 0;
        end else begin
          if (drd[i] && dq[i].size() > 0) void'(dq[i].pop_front());
          if (vrd[i] && dcnt[i] > 0) dcnt[i]--;
        end
      end
      if (rand_stall) stall_mask = N'($urandom_range(0, (1 << N) - 1));
      refreshInputs();
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pkt = 0;
      end else begin
        checkOutput("rd_onehot", 200'({$onehot0(ch_data_rd), $onehot0(ch_valid_rd)}), 200'(2'b11));
        if (ch_data_rd != 0)
          checkOutput("rd_granted_only", 200'(ch_data_rd), 200'(N'(1) << cur_grant));
        if (ch_valid_rd != 0) begin
          if (exp_grant_q.size() == 0) recordFail("unexpected_grant", int'(ch_valid_rd));
          else begin
            cur_grant = exp_grant_q.pop_front();
            checkOutput("grant", 200'(ch_valid_rd), 200'(N'(1) << cur_grant));
          end
        end
        if (pktout_data_wr) begin
          if (exp_q.size() == 0) recordFail("unexpected_word", int'(pktout_src_ch));
          else begin
            e = exp_q.pop_front();
            checkOutput("data", 200'(pktout_data), 200'(e.data));
            checkOutput("src_ch", 200'(pktout_src_ch), 200'(e.ch));
            checkOutput("tail_flags", 200'({pktout_data_valid, pktout_data_valid_wr}),
                        200'(e.tail ? 2'b11 : 2'b00));
            if (!in_pkt) gap = 0;
            in_pkt = !e.tail;
          end
        end else begin
          checkOutput("idle_flags", 200'({pktout_data_valid, pktout_data_valid_wr}), 200'(2'b00));
          if (in_pkt) gap++;
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    compared        = 0;
    failed          = 0;
    gap             = 0;
    cur_grant       = 0;
    rst             = 1'b1;
    cnt_rst         = 1'b0;
    pktout_data_alf = 1'b0;
    stall_mask      = '0;
    rand_stall      = 0;
    for (int i = 0; i < N; i++) dcnt[i] = 0;
    clearModel();
    refreshInputs();
    repeat (3) @(negedge clk);
    checkResetState("reset_state");
    rst = 1'b0;

    $display("[TB] single ch1 packet");
    applyStimulus(1, 4, 0);
    modelSchedule();
    waitDrain(200);
    checkCounters("single");

    $display("[TB] all channels, two packets each, from reset");
    resetDut();
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < N; c++) applyStimulus(c, $urandom_range(2, 6), 0);
    modelSchedule();
    waitDrain(500);
    checkCounters("rr8");

    $display("[TB] almost-full hold and mid-packet assertion");
    pktout_data_alf = 1'b1;
    applyStimulus(0, 5, 0);
    modelSchedule();
    repeat (5) begin
      @(negedge clk);
      checkOutput("alf_hold", 200'(ch_valid_rd), 200'(0));
    end
    pktout_data_alf = 1'b0;
    @(negedge clk);
    checkOutput("alf_release", 200'(ch_valid_rd), 200'(4'b0001));
    waitWord(20);
    pktout_data_alf = 1'b1;
    waitDrain(100);
    checkCounters("alf");
    pktout_data_alf = 1'b0;

    $display("[TB] ch2 data stall mid-packet");
    applyStimulus(2, 6, 0);
    modelSchedule();
    waitWord(20);
    stall_mask[2] = 1'b1;
    refreshInputs();
    repeat (5) @(negedge clk);
    stall_mask[2] = 1'b0;
    refreshInputs();
    waitDrain(100);
    checkOutput("stall_gap", 200'(gap), 200'(5));
    checkCounters("stall");

    $display("[TB] bad head and counter clear");
    @(negedge clk);
    cnt_rst = 1'b1;
    @(negedge clk);
    cnt_rst = 1'b0;
    m_pkt = 0;
    m_err = 0;
    applyStimulus(3, 3, 1);
    modelSchedule();
    waitDrain(100);
    checkCounters("bad_head");
    applyStimulus(1, 4, 0);
    modelSchedule();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ch_data_rd[1] && ch_data_rdata[2*W-1 -: 2] == 2'b10) && n < 50);
    if (!(ch_data_rd[1] && ch_data_rdata[2*W-1 -: 2] == 2'b10)) recordFail("tail_wait_timeout", n);
    cnt_rst = 1'b1;
    @(negedge clk);
    cnt_rst = 1'b0;
    m_pkt = 0;
    m_err = 0;
    waitDrain(100);
    checkCounters("clear_at_tail");

    $display("[TB] randomized batches");
    rand_stall = 1;
    for (int b = 0; b < 6; b++) begin
      for (int c = 0; c < N; c++) begin
        n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) applyStimulus(c, $urandom_range(2, 9), ($urandom_range(0, 5) == 0));
      end
      modelSchedule();
      waitDrain(3000);
      checkCounters("random");
    end
    rand_stall = 0;
    @(negedge clk);
    stall_mask = '0;
    refreshInputs();

    $display("[TB] reset mid-packet");
    applyStimulus(1, 6, 0);
    modelSchedule();
    waitWord(20);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("reset_mid_packet");
    rst = 1'b0;
    clearModel();
    applyStimulus(2, 3, 0);
    applyStimulus(0, 3, 0);
    modelSchedule();
    waitDrain(200);
    checkCounters("after_reset");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
